// File: rtl/alu_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter_if
// Purpose  : Requester, response and ALU-side signals of the ALU arbiter.
// Revision : 1.0
// ============================================================================
interface alu_req_arbiter_if #(
    parameter int W = 4
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [2:0]   req1_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_out;
    logic         rsp_cf;
    logic         rsp_of;
    logic         rsp_zf;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_out;
    logic         alu_cf;
    logic         alu_of;
    logic         alu_zf;
    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_cf, rsp_of, rsp_zf,
        input  rsp_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_cf, alu_of, alu_zf,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_cf, rsp_of, rsp_zf,
        output rsp_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_cf, alu_of, alu_zf,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter
// Purpose  : Round-robin sequencer sharing one combinational ALU between two
//            requesters, with a registered response channel.
// Revision : 1.0
// ============================================================================
module alu_req_arbiter #(
    parameter int W = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_req_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       r_state;
    logic         r_rr;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [2:0]   r_op;
    logic         r_id;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [W-1:0] r_rsp_out;
    logic         r_rsp_cf;
    logic         r_rsp_of;
    logic         r_rsp_zf;

    logic w_any;
    logic w_gid;
    logic w_idle;
    logic w_arith;
    logic w_unused;

    assign w_any   = bus.req0_valid | bus.req1_valid;
    // Contention resolves to the pointer; otherwise the lone valid requester wins.
    assign w_gid   = (bus.req0_valid & bus.req1_valid) ? r_rr : bus.req1_valid;
    assign w_idle  = (r_state == S_IDLE) & ~rst;
    assign w_arith = (r_op[2:1] == 2'b00);
    assign w_unused = bus.alu_zf;

    assign bus.req0_ready = w_idle & w_any & ~w_gid;
    assign bus.req1_ready = w_idle & w_any &  w_gid;

    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.alu_sel   = r_op;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_out   = r_rsp_out;
    assign bus.rsp_cf    = r_rsp_cf;
    assign bus.rsp_of    = r_rsp_of;
    assign bus.rsp_zf    = r_rsp_zf;
    assign bus.busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_out   <= '0;
            r_rsp_cf    <= 1'b0;
            r_rsp_of    <= 1'b0;
            r_rsp_zf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_gid ? bus.req1_a  : bus.req0_a;
                        r_b     <= w_gid ? bus.req1_b  : bus.req0_b;
                        r_op    <= w_gid ? bus.req1_op : bus.req0_op;
                        r_id    <= w_gid;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Zero flag is derived here so ALU zf quirks cannot leak out.
                    r_rsp_out   <= bus.alu_out;
                    r_rsp_cf    <= w_arith & bus.alu_cf;
                    r_rsp_of    <= w_arith & bus.alu_of;
                    r_rsp_zf    <= (bus.alu_out == '0);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr        <= ~r_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
